// File: rtl/hls_seq_pkg.sv
// rtl/hls_seq_pkg.sv - shared state type and slave-bus lane helpers for the kernel run sequencer
package hls_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_REQ,
    ST_LOAD_WAIT,
    ST_START,
    ST_RUN,
    ST_READ_REQ,
    ST_READ_WAIT,
    ST_READ_OUT,
    ST_STATUS
  } seq_state_e;

  localparam int ACCESS_SIZE_BITS = 8;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/hls_slave_access.sv
// rtl/hls_slave_access.sv - single-outstanding access engine driving lane 0 of the kernel slave port
module hls_slave_access
  import hls_seq_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int SIZE_W   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic                       ready,
  output logic                       done,
  output logic [DATA_W-1:0]          rdata,
  output logic [CHANNELS-1:0]        S_oe_ram,
  output logic [CHANNELS-1:0]        S_we_ram,
  output logic [CHANNELS*ADDR_W-1:0] S_addr_ram,
  output logic [CHANNELS*DATA_W-1:0] S_Wdata_ram,
  output logic [CHANNELS*SIZE_W-1:0] S_data_ram_size,
  input  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [CHANNELS-1:0]        Sout_DataRdy
);

  localparam int ADDR_LSB = lane_lsb(0, ADDR_W);
  localparam int DATA_LSB = lane_lsb(0, DATA_W);
  localparam int SIZE_LSB = lane_lsb(0, SIZE_W);

  logic pending_q, pending_d;
  logic issue;

  // DataRdy only counts once the request cycle is over, so it is gated by pending_q.
  assign issue = req & ~pending_q;
  assign ready = ~pending_q;
  assign done  = pending_q & Sout_DataRdy[0];
  assign rdata = Sout_Rdata_ram[DATA_LSB +: DATA_W];

  always_comb begin
    pending_d = pending_q;
    if (issue) begin
      pending_d = 1'b1;
    end else if (done) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    S_oe_ram        = '0;
    S_we_ram        = '0;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;
    if (issue) begin
      S_oe_ram[0]                           = ~we;
      S_we_ram[0]                           = we;
      S_addr_ram[ADDR_LSB +: ADDR_W]        = addr;
      S_Wdata_ram[DATA_LSB +: DATA_W]       = we ? wdata : '0;
      S_data_ram_size[SIZE_LSB +: SIZE_W]   = SIZE_W'(ACCESS_SIZE_BITS);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  if (CHANNELS > 1) begin : g_unused_lanes
    logic unused_lanes;
    assign unused_lanes = ^{Sout_Rdata_ram[CHANNELS*DATA_W-1:DATA_W], Sout_DataRdy[CHANNELS-1:1]};
  end

endmodule

// File: rtl/hls_kernel_run_sequencer.sv
// rtl/hls_kernel_run_sequencer.sv - load, start, time, read back and report one HLS kernel run per command
module hls_kernel_run_sequencer
  import hls_seq_pkg::*;
#(
  parameter int          CHANNELS = 2,
  parameter int          ADDR_W   = 7,
  parameter int          DATA_W   = 8,
  parameter int          SIZE_W   = 4,
  parameter int          LEN_W    = 8,
  parameter int          CYC_W    = 32,
  parameter int unsigned TIMEOUT  = 200000000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDR_W-1:0]          cmd_ld_base,
  input  logic [LEN_W-1:0]           cmd_ld_len,
  input  logic [ADDR_W-1:0]          cmd_rd_base,
  input  logic [LEN_W-1:0]           cmd_rd_len,
  input  logic                       ld_valid,
  input  logic [DATA_W-1:0]          ld_data,
  output logic                       ld_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  input  logic                       rd_ready,
  output logic                       acc_start_port,
  input  logic                       acc_done_port,
  output logic [CHANNELS-1:0]        S_oe_ram,
  output logic [CHANNELS-1:0]        S_we_ram,
  output logic [CHANNELS*ADDR_W-1:0] S_addr_ram,
  output logic [CHANNELS*DATA_W-1:0] S_Wdata_ram,
  output logic [CHANNELS*SIZE_W-1:0] S_data_ram_size,
  input  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [CHANNELS-1:0]        Sout_DataRdy,
  output logic                       stat_valid,
  output logic [CYC_W-1:0]           stat_cycles,
  output logic                       stat_timeout,
  output logic                       busy
);

  if (TIMEOUT == 0 || (CYC_W < 64 && 64'(TIMEOUT) >= (64'd1 << CYC_W))) begin : g_timeout_check
    $error("TIMEOUT must be nonzero and fit in CYC_W bits");
  end

  localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);

  seq_state_e        state_q, state_d, after_run;
  logic [ADDR_W-1:0] ld_base_q, ld_base_d, rd_base_q, rd_base_d;
  logic [LEN_W-1:0]  ld_len_q, ld_len_d, rd_len_q, rd_len_d, idx_q, idx_d, idx_inc;
  logic [CYC_W-1:0]  cyc_q, cyc_d, cyc_inc, stat_cycles_q, stat_cycles_d;
  logic              stat_timeout_q, stat_timeout_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              acc_req, acc_we, acc_ready, acc_done;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata, acc_rdata;

  always_comb begin
    state_d        = state_q;
    ld_base_d      = ld_base_q;
    rd_base_d      = rd_base_q;
    ld_len_d       = ld_len_q;
    rd_len_d       = rd_len_q;
    idx_d          = idx_q;
    cyc_d          = cyc_q;
    stat_cycles_d  = stat_cycles_q;
    stat_timeout_d = stat_timeout_q;
    rd_data_d      = rd_data_q;
    acc_req        = 1'b0;
    acc_we         = 1'b0;
    acc_addr       = '0;
    acc_wdata      = '0;
    idx_inc        = idx_q + LEN_W'(1);
    cyc_inc        = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);
    after_run      = (rd_len_q == '0) ? ST_STATUS : ST_READ_REQ;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ld_base_d      = cmd_ld_base;
          rd_base_d      = cmd_rd_base;
          ld_len_d       = cmd_ld_len;
          rd_len_d       = cmd_rd_len;
          idx_d          = '0;
          stat_cycles_d  = '0;
          stat_timeout_d = 1'b0;
          state_d        = (cmd_ld_len == '0) ? ST_START : ST_LOAD_REQ;
        end
      end
      ST_LOAD_REQ: begin
        acc_we    = 1'b1;
        acc_addr  = ld_base_q + ADDR_W'(idx_q);
        acc_wdata = ld_data;
        acc_req   = ld_valid;
        if (ld_valid && acc_ready) state_d = ST_LOAD_WAIT;
      end
      ST_LOAD_WAIT: begin
        if (acc_done) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == ld_len_q) ? ST_START : ST_LOAD_REQ;
        end
      end
      ST_START: begin
        // The start cycle itself counts as cycle 1.
        cyc_d = CYC_W'(1);
        idx_d = '0;
        if (acc_done_port) begin
          stat_cycles_d = CYC_W'(1);
          state_d       = after_run;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_inc;
        if (acc_done_port) begin
          stat_cycles_d = cyc_inc;
          state_d       = after_run;
        end else if (cyc_inc >= TIMEOUT_C) begin
          stat_cycles_d  = TIMEOUT_C;
          stat_timeout_d = 1'b1;
          state_d        = ST_STATUS;
        end
      end
      ST_READ_REQ: begin
        acc_req  = 1'b1;
        acc_addr = rd_base_q + ADDR_W'(idx_q);
        if (acc_ready) state_d = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        if (acc_done) begin
          rd_data_d = acc_rdata;
          state_d   = ST_READ_OUT;
        end
      end
      ST_READ_OUT: begin
        if (rd_ready) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == rd_len_q) ? ST_STATUS : ST_READ_REQ;
        end
      end
      ST_STATUS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ld_base_q      <= '0;
      rd_base_q      <= '0;
      ld_len_q       <= '0;
      rd_len_q       <= '0;
      idx_q          <= '0;
      cyc_q          <= '0;
      stat_cycles_q  <= '0;
      stat_timeout_q <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      ld_base_q      <= ld_base_d;
      rd_base_q      <= rd_base_d;
      ld_len_q       <= ld_len_d;
      rd_len_q       <= rd_len_d;
      idx_q          <= idx_d;
      cyc_q          <= cyc_d;
      stat_cycles_q  <= stat_cycles_d;
      stat_timeout_q <= stat_timeout_d;
      rd_data_q      <= rd_data_d;
    end
  end

  hls_slave_access #(
    .CHANNELS(CHANNELS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .SIZE_W  (SIZE_W)
  ) u_slave_access (
    .clock          (clock),
    .reset          (reset),
    .req            (acc_req),
    .we             (acc_we),
    .addr           (acc_addr),
    .wdata          (acc_wdata),
    .ready          (acc_ready),
    .done           (acc_done),
    .rdata          (acc_rdata),
    .S_oe_ram       (S_oe_ram),
    .S_we_ram       (S_we_ram),
    .S_addr_ram     (S_addr_ram),
    .S_Wdata_ram    (S_Wdata_ram),
    .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram (Sout_Rdata_ram),
    .Sout_DataRdy   (Sout_DataRdy)
  );

  assign cmd_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign ld_ready       = (state_q == ST_LOAD_REQ) & acc_ready;
  assign rd_valid       = (state_q == ST_READ_OUT);
  assign rd_data        = rd_data_q;
  assign acc_start_port = (state_q == ST_START);
  assign stat_valid     = (state_q == ST_STATUS);
  assign stat_cycles    = stat_cycles_q;
  assign stat_timeout   = stat_timeout_q;

endmodule

// File: tb/tb_hls_kernel_run_sequencer.sv
// tb/tb_hls_kernel_run_sequencer.sv - directed self-checking bench for the kernel run sequencer
module tb_hls_kernel_run_sequencer;

  logic        clock, reset;
  logic        cmd_valid, cmd_ready;
  logic [6:0]  cmd_ld_base, cmd_rd_base;
  logic [7:0]  cmd_ld_len, cmd_rd_len;
  logic        ld_valid, ld_ready;
  logic [7:0]  ld_data;
  logic        rd_valid, rd_ready;
  logic [7:0]  rd_data;
  logic        acc_start_port, acc_done_port;
  logic [1:0]  S_oe_ram, S_we_ram;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram;
  logic [7:0]  S_data_ram_size;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;
  logic        stat_valid;
  logic [31:0] stat_cycles;
  logic        stat_timeout;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [0:127];
  logic [7:0] ld_buf [0:7];
  logic [7:0] rd_buf [0:7];
  logic [6:0] we_log [0:15];
  logic [6:0] sl_addr;
  logic [7:0] k_tmp;
  int sl_cnt = 0, sl_lat = 1, sl_overlap = 0, size_err = 0, ch1_err = 0;
  int we_n = 0, oe_n = 0;
  int k_cnt = 0, k_delay = 20, k_sort = 0;

  hls_kernel_run_sequencer #(.TIMEOUT(50)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ld_base(cmd_ld_base), .cmd_ld_len(cmd_ld_len),
    .cmd_rd_base(cmd_rd_base), .cmd_rd_len(cmd_rd_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .acc_start_port(acc_start_port), .acc_done_port(acc_done_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .stat_valid(stat_valid), .stat_cycles(stat_cycles),
    .stat_timeout(stat_timeout), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Slave memory and kernel models, evaluated mid-cycle after the negedge.
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    Sout_DataRdy = '0; Sout_Rdata_ram = '0; acc_done_port = 1'b0;
    forever begin
      @(negedge clock); #2;
      Sout_DataRdy = '0; Sout_Rdata_ram = '0; acc_done_port = 1'b0;
      if (S_oe_ram[1] || S_we_ram[1]) ch1_err++;
      if (S_oe_ram[0] && S_we_ram[0]) sl_overlap++;
      if (sl_cnt > 0) begin
        if (S_we_ram[0] || S_oe_ram[0]) sl_overlap++;
        sl_cnt--;
        if (sl_cnt == 0) begin
          Sout_DataRdy[0] = 1'b1;
          Sout_Rdata_ram[7:0] = mem[sl_addr];
        end
      end
      if (S_we_ram[0] || S_oe_ram[0]) begin
        sl_addr = S_addr_ram[6:0];
        sl_cnt = sl_lat;
        if (S_data_ram_size[3:0] != 4'd8) size_err++;
        if (S_we_ram[0]) begin
          mem[sl_addr] = S_Wdata_ram[7:0];
          if (we_n < 16) we_log[we_n] = sl_addr;
          we_n++;
        end else begin
          oe_n++;
        end
      end
      if (k_cnt > 0) begin
        k_cnt--;
        if (k_cnt == 0) begin
          acc_done_port = 1'b1;
          if (k_sort != 0)
            for (int a = 0; a < 3; a++)
              for (int b = 0; b < 3 - a; b++)
                if (mem[b] > mem[b+1]) begin
                  k_tmp = mem[b]; mem[b] = mem[b+1]; mem[b+1] = k_tmp;
                end
        end
      end
      if (acc_start_port) begin
        if (k_delay == 0) acc_done_port = 1'b1;
        else if (k_delay > 0) k_cnt = k_delay;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [6:0] lb, input logic [7:0] ll, input logic [6:0] rb, input logic [7:0] rl);
    int k = 0;
    while (!cmd_ready && k < 200) begin tick(); k++; end
    chk("cmd_ready_wait", 64'(k < 200), 64'd1);
    cmd_valid = 1'b1; cmd_ld_base = lb; cmd_ld_len = ll; cmd_rd_base = rb; cmd_rd_len = rl;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic load_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      ld_valid = 1'b1; ld_data = ld_buf[i];
      while (!ld_ready && k < 200) begin tick(); k++; end
      chk("ld_ready_wait", 64'(k < 200), 64'd1);
      tick();
    end
    ld_valid = 1'b0;
  endtask

  task automatic collect(input int n);
    int got = 0;
    int k = 0;
    rd_ready = 1'b1;
    while (got < n && k < 500) begin
      if (rd_valid) begin rd_buf[got] = rd_data; got++; end
      tick(); k++;
    end
    chk("rd_count", 64'(got), 64'(n));
  endtask

  task automatic wait_stat();
    int k = 0;
    while (!stat_valid && k < 500) begin tick(); k++; end
    chk("stat_seen", 64'(stat_valid), 64'd1);
  endtask

  task automatic stat_tail(input string tag, input logic [31:0] cyc);
    tick();
    chk({tag, "_stat_valid_drop"}, 64'(stat_valid), 64'd0);
    chk({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_stat_cycles_held"}, 64'(stat_cycles), 64'(cyc));
  endtask

  initial begin
    int k;
    int snap;
    logic [7:0] d0;
    logic stable;
    reset = 1'b1; cmd_valid = 1'b0; cmd_ld_base = '0; cmd_ld_len = '0;
    cmd_rd_base = '0; cmd_rd_len = '0; ld_valid = 1'b0; ld_data = '0; rd_ready = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_flags", {57'd0, busy, ld_ready, rd_valid, acc_start_port, stat_valid, stat_timeout, 1'b0}, 64'd0);
    chk("rst_stat_cycles", 64'(stat_cycles), 64'd0);
    chk("rst_s_bus", {60'd0, S_oe_ram, S_we_ram}, 64'd0);
    reset = 1'b0;
    tick();

    // Test 1: load, sort, read back
    k_sort = 1; k_delay = 20; sl_lat = 1;
    ld_buf[0] = 8'h03; ld_buf[1] = 8'h01; ld_buf[2] = 8'h04; ld_buf[3] = 8'h02;
    send_cmd(7'd0, 8'd4, 7'd0, 8'd4);
    load_bytes(4);
    collect(4);
    chk("t1_readback", 64'({rd_buf[0], rd_buf[1], rd_buf[2], rd_buf[3]}), 64'h01020304);
    wait_stat();
    chk("t1_stat_cycles", 64'(stat_cycles), 64'd21);
    chk("t1_stat_timeout", 64'(stat_timeout), 64'd0);
    stat_tail("t1", 32'd21);
    k_sort = 0;

    // Test 2: zero lengths, done in the start cycle
    k_delay = 0; snap = we_n + oe_n;
    send_cmd(7'd0, 8'd0, 7'd0, 8'd0);
    k = 0;
    while (!acc_start_port && k < 50) begin tick(); k++; end
    chk("t2_start_seen", 64'(acc_start_port), 64'd1);
    chk("t2_stat_cleared", 64'(stat_cycles), 64'd0);
    chk("t2_no_stat_in_start", 64'(stat_valid), 64'd0);
    tick();
    chk("t2_start_pulse_once", 64'(acc_start_port), 64'd0);
    chk("t2_stat_valid_next", 64'(stat_valid), 64'd1);
    chk("t2_stat_cycles", 64'(stat_cycles), 64'd1);
    chk("t2_no_s_activity", 64'(we_n + oe_n), 64'(snap));
    stat_tail("t2", 32'd1);

    // Test 3: kernel never finishes
    k_delay = -1; snap = oe_n;
    send_cmd(7'd0, 8'd0, 7'd0, 8'd2);
    wait_stat();
    chk("t3_stat_timeout", 64'(stat_timeout), 64'd1);
    chk("t3_stat_cycles", 64'(stat_cycles), 64'd50);
    chk("t3_no_oe", 64'(oe_n), 64'(snap));
    stat_tail("t3", 32'd50);

    // Test 4: wrapped load addresses, slow slave
    k_delay = 5; sl_lat = 3; we_n = 0;
    ld_buf[0] = 8'hA1; ld_buf[1] = 8'hB2; ld_buf[2] = 8'hC3; ld_buf[3] = 8'hD4;
    send_cmd(7'd126, 8'd4, 7'd126, 8'd4);
    load_bytes(4);
    collect(4);
    chk("t4_we_count", 64'(we_n), 64'd4);
    chk("t4_we_addr", 64'({1'b0, we_log[0], 1'b0, we_log[1], 1'b0, we_log[2], 1'b0, we_log[3]}), 64'h7E7F0001);
    chk("t4_readback", 64'({rd_buf[0], rd_buf[1], rd_buf[2], rd_buf[3]}), 64'hA1B2C3D4);
    chk("t4_one_outstanding", 64'(sl_overlap), 64'd0);
    wait_stat();
    chk("t4_stat_cycles", 64'(stat_cycles), 64'd6);
    stat_tail("t4", 32'd6);

    // Test 5: downstream stall on the first byte
    k_delay = 2; sl_lat = 1; rd_ready = 1'b0;
    send_cmd(7'd0, 8'd0, 7'd126, 8'd2);
    k = 0;
    while (!rd_valid && k < 200) begin tick(); k++; end
    chk("t5_rd_valid_seen", 64'(rd_valid), 64'd1);
    d0 = rd_data; snap = oe_n; stable = 1'b1;
    repeat (10) begin
      tick();
      if (!rd_valid || rd_data !== d0) stable = 1'b0;
    end
    chk("t5_stall_stable", 64'(stable), 64'd1);
    chk("t5_first_byte", 64'(d0), 64'hA1);
    chk("t5_no_oe_while_stalled", 64'(oe_n), 64'(snap));
    collect(2);
    chk("t5_readback", 64'({rd_buf[0], rd_buf[1]}), 64'hA1B2);
    wait_stat();
    chk("t5_stat_cycles", 64'(stat_cycles), 64'd3);
    stat_tail("t5", 32'd3);

    // Test 6: reset while a write is outstanding
    k_delay = 3; sl_lat = 3;
    send_cmd(7'd20, 8'd2, 7'd20, 8'd2);
    ld_valid = 1'b1; ld_data = 8'h5A; k = 0;
    while (!ld_ready && k < 200) begin tick(); k++; end
    chk("t6_ld_ready_seen", 64'(ld_ready), 64'd1);
    tick();
    ld_valid = 1'b0;
    chk("t6_in_load_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    chk("t6_s_bus_cleared", {S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size}, 64'd0);
    chk("t6_busy_low", 64'(busy), 64'd0);
    chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    reset = 1'b0;
    stable = 1'b1;
    repeat (6) begin
      tick();
      if (busy || S_oe_ram != 2'b00 || S_we_ram != 2'b00) stable = 1'b0;
    end
    chk("t6_late_rdy_ignored", 64'(stable), 64'd1);
    sl_lat = 1;
    ld_buf[0] = 8'h66; ld_buf[1] = 8'h77;
    send_cmd(7'd20, 8'd2, 7'd20, 8'd2);
    load_bytes(2);
    collect(2);
    chk("t6_readback", 64'({rd_buf[0], rd_buf[1]}), 64'h6677);
    wait_stat();
    chk("t6_stat_cycles", 64'(stat_cycles), 64'd4);
    stat_tail("t6", 32'd4);

    chk("bus_overlap_total", 64'(sl_overlap), 64'd0);
    chk("bus_size_field", 64'(size_err), 64'd0);
    chk("bus_channel1_idle", 64'(ch1_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
